// File: rtl/bitepic_pkg.sv
// rtl/bitepic_pkg.sv - shared widths, bubble encoding and fetch FSM states for the BitEpicness pipeline
package bitepic_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {instr, pc} holder for a word fetched while REG is stalled
//  clk, reset        : clock, asynchronous active-low reset
//  load              : capture load_instr/load_pc, set valid
//  unload            : entry consumed, clear valid
//  clear             : discard entry (flush), wins over load
//  load_instr/pc     : data to capture
//  valid, instr, pc  : current entry
module fetch_skid_buffer #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear || unload) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, one-outstanding imem request, stall skid, redirect flush
//  clk, reset                 : clock, asynchronous active-low reset
//  imem_req, imem_addr        : request to instruction memory, held stable until imem_ack
//  imem_ack, imem_rdata       : request completion and fetched word
//  stall                      : REG stage cannot accept, REG_* hold
//  redirect, redirect_pc      : flush and restart fetch at redirect_pc
//  REG_Instruction/PC/Mask    : registered slot into REG stage, Mask=1 marks a bubble
module fetch_stage #(
  parameter int                 PC_W      = bitepic_pkg::PC_W,
  parameter int                 INSTR_W   = bitepic_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = bitepic_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] REG_Instruction,
  output logic [PC_W-1:0]    REG_PC,
  output logic               REG_Mask
);

  import bitepic_pkg::*;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [PC_W-1:0]    req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] reg_instr_d;
  logic [PC_W-1:0]    reg_pc_d;
  logic               reg_mask_d;

  logic               skid_load, skid_unload, skid_clear, skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  fetch_skid_buffer #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (req_addr_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // DROP keeps the already-issued request alive: memory requests are never aborted.
  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = req_addr_q;
  assign pc_inc    = pc_q + PC_ONE;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    reg_instr_d = REG_Instruction;
    reg_pc_d    = REG_PC;
    reg_mask_d  = REG_Mask;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (state_q == START) begin
      state_d    = FETCH;
      req_addr_d = pc_q;
    end else if (redirect) begin
      // Redirect beats stall: the REG slot is flushed, REG_PC keeps its old value.
      pc_d        = redirect_pc;
      reg_mask_d  = 1'b1;
      reg_instr_d = NOP_INSTR;
      skid_clear  = 1'b1;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            req_addr_d = redirect_pc;
          end else begin
            state_d = DROP;
          end
        end
        HOLD: begin
          state_d    = FETCH;
          req_addr_d = redirect_pc;
        end
        DROP: begin
          if (imem_ack) begin
            state_d    = FETCH;
            req_addr_d = redirect_pc;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
            if (!stall) begin
              reg_instr_d = imem_rdata;
              reg_pc_d    = req_addr_q;
              reg_mask_d  = 1'b0;
            end else begin
              // Word arrived but REG is blocked: park it and stop requesting.
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (!stall) begin
            reg_mask_d  = 1'b1;
            reg_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            reg_instr_d = skid_instr;
            reg_pc_d    = skid_pc;
            reg_mask_d  = !skid_valid;
            skid_unload = 1'b1;
            state_d     = FETCH;
            req_addr_d  = pc_q;
          end
        end
        DROP: begin
          // Stale response: discard and restart at the redirected PC.
          if (imem_ack) begin
            state_d    = FETCH;
            req_addr_d = pc_q;
          end
        end
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= START;
      pc_q            <= RESET_PC;
      req_addr_q      <= RESET_PC;
      REG_Instruction <= NOP_INSTR;
      REG_PC          <= '0;
      REG_Mask        <= 1'b1;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_addr_q      <= req_addr_d;
      REG_Instruction <= reg_instr_d;
      REG_PC          <= reg_pc_d;
      REG_Mask        <= reg_mask_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr, imem_rdata = 16'h0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] REG_Instruction, REG_PC;
  logic        REG_Mask;

  logic        w_req, w_ack, w_mask;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc;

  always #5 clk = ~clk;

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .REG_Instruction(REG_Instruction), .REG_PC(REG_PC),
    .REG_Mask(REG_Mask)
  );

  // Second instance starting at the top of the address space, memory acks immediately.
  assign w_ack   = w_req;
  assign w_rdata = w_addr + 16'h1000;

  fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) dut_wrap (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(16'h0000), .REG_Instruction(w_instr), .REG_PC(w_pc), .REG_Mask(w_mask)
  );

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the REG stage must see addresses base, base+1, ... (mod 2^16)
  // restarting at each redirect target, each carrying mem(addr) = addr + 16'h1000.
  logic [31:0] exp_q[$];
  logic [15:0] gen_pc = 16'h0;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({gen_pc + 16'h1000, gen_pc});
      gen_pc = gen_pc + 16'h1;
    end
  endtask

  task automatic restart_stream(input logic [15:0] base);
    exp_q.delete();
    gen_pc = base;
    refill();
  endtask

  // Memory model: random latency 0..max_lat, never acks while mem_hold.
  int   max_lat = 0;
  bit   mem_hold = 1'b0;
  bit   busy = 1'b0;
  int   wait_cnt = 0;
  logic [15:0] held_addr = 16'h0;

  always @(posedge clk) begin
    #1;
    imem_ack   = 1'b0;
    imem_rdata = 16'($urandom);
    if (!reset) begin
      busy = 1'b0;
    end else if (imem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        held_addr = imem_addr;
        wait_cnt  = $urandom_range(0, max_lat);
      end else begin
        check("addr_stable", imem_addr, held_addr);
      end
      if (!mem_hold) begin
        if (wait_cnt == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr + 16'h1000;
          busy       = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      busy = 1'b0;
    end
  end

  // Monitor: a slot is consumed when valid, not stalled and not flushed.
  bit          mon_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [32:0] prev_slot = '0;

  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (prev_hold)
        check("stall_hold", {REG_Mask, REG_Instruction, REG_PC}, prev_slot);
      if (!REG_Mask && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deliver unexpected word actual=%0h required=none", {REG_Instruction, REG_PC});
        end else begin
          check("deliver", {REG_Instruction, REG_PC}, exp_q.pop_front());
          delivered++;
        end
      end
      prev_hold = stall && !redirect;
      prev_slot = {REG_Mask, REG_Instruction, REG_PC};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Wrap-around instance: first two words are FFFF then 0000.
  initial begin : wrap_chk
    int seen = 0;
    int cyc = 0;
    wait (reset === 1'b1);
    while (seen < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!w_mask) begin
        if (seen == 0) check("wrap_first", {w_instr, w_pc}, {16'h0FFF, 16'hFFFF});
        else           check("wrap_second", {w_instr, w_pc}, {16'h1000, 16'h0000});
        seen++;
      end
    end
    if (seen < 2) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout actual=%0d required=2", seen);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mask", REG_Mask, 1'b1);
    check("rst_instr", REG_Instruction, 16'h0000);
    check("rst_pc", REG_PC, 16'h0000);
    check("rst_req", imem_req, 1'b0);
    check("rst_wrap_req", w_req, 1'b0);

    // Release: START cycle, then first request at RESET_PC, data one cycle later.
    restart_stream(16'h0000);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("t1_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    check("t1_bubble", REG_Mask, 1'b1);
    @(negedge clk);
    check("t1_first", {REG_Mask, REG_Instruction, REG_PC}, {1'b0, 16'h1000, 16'h0000});
    repeat (10) begin
      @(posedge clk); #1;
      refill();
    end

    // Randomized traffic: latency, stall and redirect (including near-wrap targets).
    max_lat = 3;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      stall    = ($urandom_range(0, 99) < 30);
      redirect = ($urandom_range(0, 99) < 4);
      if (redirect) begin
        redirect_pc = (c % 5 == 0) ? 16'hFFFE : 16'($urandom);
        restart_stream(redirect_pc);
      end
      refill();
    end

    // Drain to steady FETCH, then freeze memory so a request is outstanding.
    max_lat = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      stall    = 1'b0;
      redirect = 1'b0;
      mem_hold = (c >= 5);
      refill();
    end
    @(negedge clk);
    check("t6_pending", imem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async", {imem_req, REG_Mask, REG_Instruction, REG_PC}, {1'b0, 1'b1, 16'h0000, 16'h0000});
    mem_hold = 1'b0;
    restart_stream(16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_first_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
    repeat (10) begin
      @(posedge clk); #1;
      refill();
    end
    @(negedge clk);
    check("liveness", delivered > 300, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
